// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg: shared encodings, latency defaults and MD sequencer state type
package stall_ctrl_pkg;

    localparam logic [1:0] TNEW_0    = 2'd0;
    localparam logic [1:0] TNEW_1    = 2'd1;
    localparam logic [1:0] TNEW_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/stall_ctrl_md_busy_fsm.sv
// md_busy_fsm: multiply/divide busy sequencer; busy for exactly the op latency after the start edge
module md_busy_fsm
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic E_md_start,
    input  logic E_md_is_div,
    output logic md_start,
    output logic md_busy
);

    localparam int LAT_W = $clog2((MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT) + 1);

    md_state_e        state_d, state_q;
    logic [LAT_W-1:0] cnt_d, cnt_q;

    // a start while busy is dropped: no restart and no reload
    always_comb begin
        md_start = E_md_start && state_q == IDLE;
        md_busy  = state_q == BUSY;
        state_d  = state_q;
        cnt_d    = cnt_q;
        if (md_start) begin
            state_d = BUSY;
            cnt_d   = E_md_is_div ? LAT_W'(DIV_LAT - 1) : LAT_W'(MULT_LAT - 1);
        end else if (md_busy) begin
            state_d = cnt_q == '0 ? IDLE : BUSY;
            cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline hold/bubble/redirect control with RAW and MD-busy hazard detection
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       D_rs,
    input  logic [4:0]       D_rt,
    input  logic [1:0]       D_tuse_rs,
    input  logic [1:0]       D_tuse_rt,
    input  logic             D_is_md,
    input  logic             D_redirect,
    input  logic [4:0]       E_wa,
    input  logic [1:0]       E_tnew,
    input  logic [4:0]       M_wa,
    input  logic [1:0]       M_tnew,
    input  logic             E_md_start,
    input  logic             E_md_is_div,
    output logic             pause,
    output logic             DE_flush,
    output logic             F_branch,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             hz_rs, hz_rt, hz_md, stall;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    md_busy_fsm #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md (
        .clk         (clk),
        .reset       (reset),
        .E_md_start  (E_md_start),
        .E_md_is_div (E_md_is_div),
        .md_start    (md_start),
        .md_busy     (md_busy)
    );

    // register 0 never hazards; TUSE_NONE (3) can never be exceeded by a 2-bit tnew
    always_comb begin
        hz_rs = D_rs != 5'd0 && ((D_rs == E_wa && E_tnew > D_tuse_rs) ||
                                 (D_rs == M_wa && M_tnew > D_tuse_rs));
        hz_rt = D_rt != 5'd0 && ((D_rt == E_wa && E_tnew > D_tuse_rt) ||
                                 (D_rt == M_wa && M_tnew > D_tuse_rt));
        hz_md       = D_is_md && (md_busy || md_start);
        stall       = hz_rs || hz_rt || hz_md;
        pause       = stall;
        DE_flush    = stall;
        F_branch    = D_redirect && !stall;
        stall_cnt_d = stall_cnt_q + CNT_W'(stall);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed scenarios plus random stimulus against a remaining-cycles reference model
module tb_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_wa, M_wa;
    logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic        D_is_md, D_redirect, E_md_start, E_md_is_div;
    logic        pause, DE_flush, F_branch, md_start, md_busy;
    logic [31:0] stall_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          busy_left = 0;
    logic [31:0] exp_cnt = '0;

    always #5 clk = ~clk;

    stall_ctrl dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .D_is_md(D_is_md), .D_redirect(D_redirect),
        .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
        .pause(pause), .DE_flush(DE_flush), .F_branch(F_branch),
        .md_start(md_start), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    function automatic bit raw(input logic [4:0] r, input logic [1:0] tuse);
        int need = tuse;
        if (r == 0) return 0;
        return (r == E_wa && int'(E_tnew) > need) || (r == M_wa && int'(M_tnew) > need);
    endfunction

    function automatic bit exp_start();
        return E_md_start && busy_left == 0;
    endfunction

    function automatic bit exp_stall();
        return raw(D_rs, D_tuse_rs) || raw(D_rt, D_tuse_rt) || (D_is_md && (busy_left > 0 || E_md_start));
    endfunction

    task automatic clr();
        {D_rs, D_rt, E_wa, M_wa} = '0;
        {D_tuse_rs, D_tuse_rt, E_tnew, M_tnew} = '0;
        {D_is_md, D_redirect, E_md_start, E_md_is_div} = '0;
    endtask

    task automatic tick();
        bit st = exp_stall();
        bit sr = exp_start();
        bit dv = E_md_is_div;
        @(posedge clk);
        if (reset) begin
            if (st) exp_cnt = exp_cnt + 1;
            if (sr) busy_left = dv ? 10 : 5;
            else if (busy_left > 0) busy_left = busy_left - 1;
        end
        #1;
    endtask

    task automatic test_reset();
        clr();
        reset = 1'b0;
        #3;
        n_tests += 4;
        if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
        if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        if (pause !== 1'b0) begin n_fail++; $display("FAIL reset_pause: got %b want 0", pause); end
        if (F_branch !== 1'b0) begin n_fail++; $display("FAIL reset_F_branch: got %b want 0", F_branch); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_raw();
        clr();
        E_wa = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_tuse_rs = 2'd0;
        @(negedge clk);
        n_tests += 2;
        if (pause !== 1'b1) begin n_fail++; $display("FAIL raw_pause: got %b want 1", pause); end
        if (DE_flush !== 1'b1) begin n_fail++; $display("FAIL raw_flush: got %b want 1", DE_flush); end
        tick();
        n_tests++;
        if (stall_cnt !== exp_cnt || exp_cnt !== 32'd1) begin
            n_fail++; $display("FAIL raw_stall_cnt: got %0d want 1", stall_cnt);
        end
        E_wa = 5'd0;
        @(negedge clk);
        n_tests++;
        if (pause !== 1'b0) begin n_fail++; $display("FAIL raw_clear_pause: got %b want 0", pause); end
        tick();
    endtask

    task automatic test_zero_nouse();
        clr();
        D_rs = 5'd0; E_wa = 5'd0; E_tnew = 2'd2;
        D_rt = 5'd9; M_wa = 5'd9; M_tnew = 2'd1; D_tuse_rt = 2'd3;
        @(negedge clk);
        n_tests++;
        if (pause !== 1'b0) begin n_fail++; $display("FAIL zero_nouse_pause: got %b want 0", pause); end
        D_tuse_rt = 2'd1;
        #1;
        n_tests++;
        if (pause !== 1'b0) begin n_fail++; $display("FAIL tnew_eq_tuse_pause: got %b want 0", pause); end
        D_tuse_rt = 2'd0;
        #1;
        n_tests++;
        if (pause !== 1'b1) begin n_fail++; $display("FAIL m_stage_raw_pause: got %b want 1", pause); end
        tick();
    endtask

    task automatic test_md(input bit is_div, input int lat);
        clr();
        E_md_start = 1'b1; E_md_is_div = is_div; D_is_md = 1'b1;
        @(negedge clk);
        n_tests += 3;
        if (md_start !== 1'b1) begin n_fail++; $display("FAIL md%0d_start: got %b want 1", lat, md_start); end
        if (md_busy !== 1'b0) begin n_fail++; $display("FAIL md%0d_busy_c0: got %b want 0", lat, md_busy); end
        if (pause !== 1'b1) begin n_fail++; $display("FAIL md%0d_pause_c0: got %b want 1", lat, pause); end
        tick();
        E_md_start = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (is_div && k == 3) E_md_start = 1'b1;
            @(negedge clk);
            n_tests += 3;
            if (md_busy !== 1'b1) begin n_fail++; $display("FAIL md%0d_busy_c%0d: got %b want 1", lat, k, md_busy); end
            if (md_start !== 1'b0) begin n_fail++; $display("FAIL md%0d_nostart_c%0d: got %b want 0", lat, k, md_start); end
            if (pause !== 1'b1) begin n_fail++; $display("FAIL md%0d_pause_c%0d: got %b want 1", lat, k, pause); end
            tick();
            E_md_start = 1'b0;
        end
        @(negedge clk);
        n_tests += 3;
        if (md_busy !== 1'b0) begin n_fail++; $display("FAIL md%0d_busy_end: got %b want 0", lat, md_busy); end
        if (pause !== 1'b0) begin n_fail++; $display("FAIL md%0d_pause_end: got %b want 0", lat, pause); end
        if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL md%0d_stall_cnt: got %0d want %0d", lat, stall_cnt, exp_cnt); end
        tick();
    endtask

    task automatic test_redirect();
        clr();
        D_redirect = 1'b1; D_rt = 5'd5; E_wa = 5'd5; E_tnew = 2'd1; D_tuse_rt = 2'd0;
        @(negedge clk);
        n_tests += 2;
        if (F_branch !== 1'b0) begin n_fail++; $display("FAIL redirect_stalled: got %b want 0", F_branch); end
        if (pause !== 1'b1) begin n_fail++; $display("FAIL redirect_pause: got %b want 1", pause); end
        tick();
        E_wa = 5'd0;
        @(negedge clk);
        n_tests++;
        if (F_branch !== 1'b1) begin n_fail++; $display("FAIL redirect_taken: got %b want 1", F_branch); end
        tick();
        clr();
    endtask

    task automatic test_async_reset();
        clr();
        E_md_start = 1'b1; E_md_is_div = 1'b1;
        tick();
        E_md_start = 1'b0; D_is_md = 1'b1;
        for (int k = 1; k < 4; k++) tick();
        #2;
        reset = 1'b0;
        #1;
        busy_left = 0;
        exp_cnt = '0;
        n_tests += 2;
        if (md_busy !== 1'b0) begin n_fail++; $display("FAIL async_md_busy: got %b want 0", md_busy); end
        if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL async_stall_cnt: got %0d want 0", stall_cnt); end
        D_is_md = 1'b0; E_md_start = 1'b1;
        #1;
        n_tests++;
        if (md_start !== 1'b1) begin n_fail++; $display("FAIL async_md_start_follows: got %b want 1", md_start); end
        tick();
        @(negedge clk);
        reset = 1'b1;
        #1;
        tick();
        E_md_start = 1'b0;
        #1;
        n_tests++;
        if (md_busy !== 1'b1) begin n_fail++; $display("FAIL async_restart_busy: got %b want 1", md_busy); end
        for (int k = 0; k < 20 && busy_left > 0; k++) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
            E_wa = 5'($urandom_range(0, 3)); M_wa = 5'($urandom_range(0, 3));
            D_tuse_rs = 2'($urandom_range(0, 3)); D_tuse_rt = 2'($urandom_range(0, 3));
            E_tnew = 2'($urandom_range(0, 2)); M_tnew = 2'($urandom_range(0, 2));
            D_is_md = ($urandom_range(0, 3) == 0);
            D_redirect = 1'($urandom);
            E_md_start = ($urandom_range(0, 7) == 0);
            E_md_is_div = 1'($urandom);
            @(negedge clk);
            n_tests += 6;
            if (pause !== exp_stall()) begin n_fail++; $display("FAIL rnd_pause[%0d]: got %b want %b", i, pause, exp_stall()); end
            if (DE_flush !== exp_stall()) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, DE_flush, exp_stall()); end
            if (F_branch !== (D_redirect && !exp_stall())) begin n_fail++; $display("FAIL rnd_F_branch[%0d]: got %b want %b", i, F_branch, D_redirect && !exp_stall()); end
            if (md_start !== exp_start()) begin n_fail++; $display("FAIL rnd_md_start[%0d]: got %b want %b", i, md_start, exp_start()); end
            if (md_busy !== (busy_left > 0)) begin n_fail++; $display("FAIL rnd_md_busy[%0d]: got %b want %b", i, md_busy, busy_left > 0); end
            if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL rnd_stall_cnt[%0d]: got %0d want %0d", i, stall_cnt, exp_cnt); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_zero_nouse();
        test_md(1'b0, 5);
        test_md(1'b1, 10);
        test_redirect();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Decides each cycle whether the fetch stage (PC register) and the F/D register hold, whether a bubble is inserted into D/E, and whether a D-stage redirect is applied.
- Owns the multi-cycle multiply/divide busy sequencer.
- Drives the fetch stage's pause and branch inputs directly.

Parameters:
- MULT_LAT, 5, cycles the MD unit stays busy after a mult/multu start
- DIV_LAT, 10, cycles the MD unit stays busy after a div/divu start
- CNT_W, 32, width of stall performance counter

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- D_rs  input  5  D-stage rs register number
- D_rt  input  5  D-stage rt register number
- D_tuse_rs  input  2  cycles until D needs rs (3 = not used)
- D_tuse_rt  input  2  cycles until D needs rt (3 = not used)
- D_is_md  input  1  D holds mult/div/mfhi/mflo/mthi/mtlo
- D_redirect  input  1  D-stage branch/jump taken
- E_wa  input  5  E-stage write register (0 = none)
- E_tnew  input  2  cycles until E result is ready
- M_wa  input  5  M-stage write register (0 = none)
- M_tnew  input  2  cycles until M result is ready
- E_md_start  input  1  E holds a valid mult/multu/div/divu this cycle
- E_md_is_div  input  1  qualifies E_md_start: 1 = div, 0 = mult
- pause  output  1  hold PC and F/D register
- DE_flush  output  1  load a bubble into D/E
- F_branch  output  1  redirect enable to fetch stage
- md_start  output  1  one-cycle start pulse to MD unit
- md_busy  output  1  MD unit busy
- stall_cnt  output  CNT_W  count of cycles with pause = 1

Behaviour:
Data hazard (combinational):
- hz_rs = D_rs != 0 && ((D_rs == E_wa && E_tnew > D_tuse_rs) || (D_rs == M_wa && M_tnew > D_tuse_rs)).
- hz_rt is the same expression using D_rt and D_tuse_rt.
- E_wa == 0 and M_wa == 0 never match.

MD hazard:
- hz_md = D_is_md && (md_busy || md_start).

Stall outputs:
- stall = hz_rs | hz_rt | hz_md.
- pause = DE_flush = stall.
- F_branch = D_redirect & ~stall. A stalled redirect is re-evaluated the following cycle.

MD FSM, states IDLE and BUSY:
- md_start = E_md_start && state == IDLE, combinational, same cycle.
- IDLE -> BUSY on md_start; counter loads (E_md_is_div ? DIV_LAT : MULT_LAT) - 1.
- BUSY: counter decrements each cycle. BUSY -> IDLE on the edge where counter == 0.
- md_busy = (state == BUSY). The start cycle itself is covered by hz_md through md_start.
- Net effect: md_busy is high exactly MULT_LAT or DIV_LAT cycles after the start edge.
- E_md_start while BUSY cannot occur, because hz_md blocks it. If it does occur it is ignored: no restart and no counter reload.

stall_cnt:
- Increments by 1 on every clock edge where pause = 1.
- Wraps from all-ones to 0.

Reset (reset = 0, asynchronous, any time including mid-BUSY):
- state = IDLE, counter = 0, stall_cnt = 0.
- md_busy = 0, therefore md_start follows E_md_start.
- pause, DE_flush and F_branch follow their combinational inputs. With all inputs 0 they are 0.

Release is synchronous to the next rising clk. No other latency: all control outputs are combinational from inputs and state.

Decomposition:
- Shared package holds:
  - TUSE/TNEW encodings (TNEW_0..TNEW_2, TUSE_NONE = 3)
  - MULT_LAT / DIV_LAT defaults
  - FSM state enum {IDLE, BUSY}
- One natural sub-module: md_busy_fsm, containing the state, latency counter, md_start and md_busy.
- The hazard compare stays inline in stall_ctrl.

Test Plan:
- RAW stall: E_wa=8, E_tnew=2, D_rs=8, D_tuse_rs=0 -> pause=1, DE_flush=1, stall_cnt +1. Next cycle E_wa=0 -> pause=0.
- $zero and no-use: D_rs=0 = E_wa, E_tnew=2 -> pause=0. D_rt=9=M_wa, M_tnew=1, D_tuse_rt=3 -> pause=0.
- Mult sequence: E_md_start=1, E_md_is_div=0 at cycle 0 -> md_start=1. md_busy=1 for cycles 1..5, 0 at cycle 6. D_is_md=1 during cycles 0..5 -> pause=1; cycle 6 -> pause=0.
- Div latency: same stimulus with E_md_is_div=1 -> md_busy high exactly 10 cycles. E_md_start pulsed mid-BUSY -> no md_start, no extension.
- Redirect under stall: D_redirect=1 with hz_rt=1 -> F_branch=0. Hazard cleared next cycle -> F_branch=1.
- Async reset mid-div (cycle 4 of 10), reset=0 between edges -> md_busy=0 and stall_cnt=0 immediately. Release -> IDLE, new start accepted on first edge.
